rvfi_trace_monitor: RTL and testbench



---
 rtl/rvfi_trace_monitor_if.sv | 36 +++
 rtl/rvfi_trace_monitor.sv | 146 ++++++++++++++
 tb/tb_rvfi_trace_monitor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_trace_monitor_if.sv
// RVFI retirement bundle plus the trace valid/ready stream.
// master: hart/consumer side, slave: the trace monitor.
interface rvfi_trace_monitor_if;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_halt;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_data;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_halt,
    output rvfi_rd_addr, rvfi_rd_wdata,
    output rvfi_pc_rdata, rvfi_pc_wdata,
    output rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    output trace_ready,
    input  trace_valid, trace_data
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_halt,
    input  rvfi_rd_addr, rvfi_rd_wdata,
    input  rvfi_pc_rdata, rvfi_pc_wdata,
    input  rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
    input  trace_ready,
    output trace_valid, trace_data
  );
endinterface

// File: rtl/rvfi_trace_monitor.sv
// RVFI retirement checker with sticky first-error capture and a
// {pc, insn} trace FIFO. Ports: clk, rst_n, bus (RVFI in, trace
// stream out), drop_count, err, err_code, err_order.
module rvfi_trace_monitor #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rvfi_trace_monitor_if.slave  bus,
  output logic [15:0]          drop_count,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [63:0]          err_order
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [63:0] exp_order_q, exp_order_d;
  logic [31:0] exp_pc_q, exp_pc_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [63:0] err_order_q, err_order_d;
  logic [15:0] drop_q, drop_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic [63:0] mem_q [DEPTH];

  logic        rv;
  logic        empty, full, pop, push, drop;
  ptr_t        count;
  logic [3:0]  mask;
  logic        mem_ok;
  logic [2:0]  code;
  logic        unused_addr;

  assign rv = bus.rvfi_valid;
  assign unused_addr = ^bus.rvfi_mem_addr[31:2];

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (count == ptr_t'(DEPTH));
  assign pop   = !empty && bus.trace_ready;
  // A full FIFO still takes a push when a pop frees the slot.
  assign push  = rv && (!full || pop);
  assign drop  = rv && full && !pop;

  assign bus.trace_valid = !empty;
  // Head entry cannot be overwritten until popped, so it stays stable.
  assign bus.trace_data  = empty ? 64'h0 : mem_q[rd_ptr_q[AW-1:0]];

  assign mask = bus.rvfi_mem_rmask | bus.rvfi_mem_wmask;

  always_comb begin
    mem_ok = 1'b0;
    case (mask)
      4'b0000: mem_ok = 1'b1;
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: mem_ok = 1'b1;
      4'b0011, 4'b1100: mem_ok = !bus.rvfi_mem_addr[0];
      4'b1111: mem_ok = (bus.rvfi_mem_addr[1:0] == 2'b00);
      default: mem_ok = 1'b0;
    endcase
  end

  // Lowest code wins when several checks fire together.
  always_comb begin
    code = 3'd0;
    if (bus.rvfi_order != exp_order_q)
      code = 3'd1;
    else if (bus.rvfi_pc_rdata != exp_pc_q)
      code = 3'd2;
    else if (bus.rvfi_rd_addr == 5'd0 && bus.rvfi_rd_wdata != 32'd0)
      code = 3'd3;
    else if (!mem_ok)
      code = 3'd4;
    else if (halted_q)
      code = 3'd5;
  end

  always_comb begin
    exp_order_d = exp_order_q;
    exp_pc_d    = exp_pc_q;
    halted_d    = halted_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_order_d = err_order_q;
    drop_d      = drop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (rv) begin
      exp_order_d = bus.rvfi_order + 64'd1;
      exp_pc_d    = bus.rvfi_pc_wdata;
      halted_d    = halted_q | bus.rvfi_halt;
      if (!err_q && code != 3'd0) begin
        err_d       = 1'b1;
        err_code_d  = code;
        err_order_d = bus.rvfi_order;
      end
    end
    if (push)
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (drop && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_order_q <= '0;
      exp_pc_q    <= RESET_PC;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_order_q <= '0;
      drop_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      exp_order_q <= exp_order_d;
      exp_pc_q    <= exp_pc_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_order_q <= err_order_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage is not reset; empty gating keeps trace_data at zero.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.rvfi_pc_rdata, bus.rvfi_insn};
  end

  assign drop_count = drop_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_order  = err_order_q;

endmodule

// File: tb/tb_rvfi_trace_monitor.sv
// Directed bench for rvfi_trace_monitor: trace records go through a
// scoreboard queue, error/drop state is compared after each scenario.
module tb_rvfi_trace_monitor;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] drop_count;
  logic        err;
  logic [2:0]  err_code;
  logic [63:0] err_order;

  rvfi_trace_monitor_if bus ();

  rvfi_trace_monitor #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .drop_count (drop_count),
    .err        (err),
    .err_code   (err_code),
    .err_order  (err_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int pops = 0;
  logic [63:0] sb_q [$];

  logic [4:0]  x_rd;
  logic [31:0] x_wd;
  logic [31:0] x_addr;
  logic [3:0]  x_rm;
  logic [3:0]  x_wm;
  logic        x_halt;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_extra();
    x_rd = 5'd1; x_wd = 32'h0; x_addr = 32'h0;
    x_rm = 4'h0; x_wm = 4'h0; x_halt = 1'b0;
  endtask

  // Called at posedge+1; holds one retire for one cycle.
  task automatic retire(input logic [63:0] ord,
                        input logic [31:0] pc,
                        input logic [31:0] npc,
                        input bit exp_push);
    logic [31:0] insn;
    insn = {ord[19:0], 12'h013};
    bus.rvfi_valid     = 1'b1;
    bus.rvfi_order     = ord;
    bus.rvfi_insn      = insn;
    bus.rvfi_halt      = x_halt;
    bus.rvfi_rd_addr   = x_rd;
    bus.rvfi_rd_wdata  = x_wd;
    bus.rvfi_pc_rdata  = pc;
    bus.rvfi_pc_wdata  = npc;
    bus.rvfi_mem_addr  = x_addr;
    bus.rvfi_mem_rmask = x_rm;
    bus.rvfi_mem_wmask = x_wm;
    if (exp_push) sb_q.push_back({pc, insn});
    @(posedge clk); #1;
    bus.rvfi_valid = 1'b0;
    clr_extra();
  endtask

  task automatic do_reset();
    bus.rvfi_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    pops = 0;
    #1;
    check("rst_trace_valid", {63'h0, bus.trace_valid}, 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_err(input string n, input logic e,
                         input logic [2:0] c, input logic [63:0] o);
    check({n, "_err"}, {63'h0, err}, {63'h0, e});
    check({n, "_code"}, {61'h0, err_code}, {61'h0, c});
    check({n, "_order"}, err_order, o);
  endtask

  // Scoreboard monitor: a handshake is decided at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.trace_valid && bus.trace_ready) begin
        pops++;
        if (sb_q.size() == 0)
          check("unexpected_record", bus.trace_data, 64'hx);
        else
          check("trace_record", bus.trace_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_extra();
    bus.rvfi_valid     = 1'b0;
    bus.rvfi_order     = '0;
    bus.rvfi_insn      = '0;
    bus.rvfi_halt      = 1'b0;
    bus.rvfi_rd_addr   = '0;
    bus.rvfi_rd_wdata  = '0;
    bus.rvfi_pc_rdata  = '0;
    bus.rvfi_pc_wdata  = '0;
    bus.rvfi_mem_addr  = '0;
    bus.rvfi_mem_rmask = '0;
    bus.rvfi_mem_wmask = '0;
    bus.trace_ready    = 1'b1;
    rst_n = 1'b0;
    #12;
    check("reset_trace_valid", {63'h0, bus.trace_valid}, 64'h0);
    check("reset_trace_data", bus.trace_data, 64'h0);
    check("reset_drop", {48'h0, drop_count}, 64'h0);
    chk_err("reset", 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean stream.
    for (int i = 0; i < 20; i++)
      retire(64'(i), 32'(4 * i), 32'(4 * i + 4), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_err("clean", 1'b0, 3'd0, 64'h0);
    check("clean_drop", {48'h0, drop_count}, 64'h0);
    check("clean_pops", 64'(pops), 64'd20);
    check("clean_sb_empty", 64'(sb_q.size()), 64'd0);

    // Order skip, then a pc fault that must not overwrite it.
    do_reset();
    retire(64'd0, 32'h0, 32'h4, 1'b1);
    retire(64'd1, 32'h4, 32'h8, 1'b1);
    retire(64'd3, 32'h8, 32'hC, 1'b1);
    chk_err("skip", 1'b1, 3'd1, 64'd3);
    retire(64'd4, 32'h100, 32'h104, 1'b1);
    chk_err("skip_sticky", 1'b1, 3'd1, 64'd3);

    // pc and x0 faults together.
    do_reset();
    x_rd = 5'd0; x_wd = 32'd5;
    retire(64'd0, 32'h40, 32'h44, 1'b1);
    check("prio_code", {61'h0, err_code}, 64'd2);

    // Misaligned word store.
    do_reset();
    x_wm = 4'b1111; x_addr = 32'h102;
    retire(64'd0, 32'h0, 32'h4, 1'b1);
    chk_err("word_mis", 1'b1, 3'd4, 64'd0);

    // Aligned halfword, then misaligned low halfword load.
    do_reset();
    x_wm = 4'b1100; x_addr = 32'h102;
    retire(64'd0, 32'h0, 32'h4, 1'b1);
    check("half_ok", {63'h0, err}, 64'h0);
    x_rm = 4'b0011; x_addr = 32'h101;
    retire(64'd1, 32'h4, 32'h8, 1'b1);
    chk_err("half_mis", 1'b1, 3'd4, 64'd1);

    // Overflow, then push and pop on a full FIFO.
    bus.trace_ready = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++)
      retire(64'(i), 32'(4 * i), 32'(4 * i + 4), i < DEPTH);
    check("ovf_drop", {48'h0, drop_count}, 64'd3);
    check("ovf_valid", {63'h0, bus.trace_valid}, 64'h1);
    bus.trace_ready = 1'b1;
    retire(64'(DEPTH + 3), 32'(4 * (DEPTH + 3)),
           32'(4 * (DEPTH + 4)), 1'b1);
    check("full_pushpop_drop", {48'h0, drop_count}, 64'd3);
    for (int n = 0; n < 40; n++) begin
      if (sb_q.size() == 0 && !bus.trace_valid) break;
      @(posedge clk); #1;
    end
    check("ovf_pops", 64'(pops), 64'(DEPTH + 1));
    check("ovf_drained", {63'h0, bus.trace_valid}, 64'h0);
    check("ovf_err", {63'h0, err}, 64'h0);

    // Halt then retire; reset while records are pending.
    bus.trace_ready = 1'b0;
    do_reset();
    x_halt = 1'b1;
    retire(64'd0, 32'h0, 32'h4, 1'b1);
    check("halt_first_ok", {63'h0, err}, 64'h0);
    retire(64'd1, 32'h4, 32'h8, 1'b1);
    chk_err("halt", 1'b1, 3'd5, 64'd1);
    bus.trace_ready = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_valid", {63'h0, bus.trace_valid}, 64'h1);
    do_reset();
    retire(64'd0, 32'h0, 32'h4, 1'b1);
    check("post_rst_err", {63'h0, err}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pops", 64'(pops), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
